// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one memory-mapped FPU among N_REQ requesters:
// write A, write B, write command, wait for the registered result, pulse it back.
module fpu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int RESULT_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 busy,
    output logic                 fpu_cs,
    output logic [12:0]          fpu_addr,
    output logic [31:0]          fpu_wdata,
    input  logic [31:0]          fpu_rdata
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

    localparam logic [12:0] ADDR_A   = 13'h000;
    localparam logic [12:0] ADDR_B   = 13'h004;
    localparam logic [12:0] ADDR_CMD = 13'h008;

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_CMD, WAIT, RESP} state_t;

    state_t           state;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand;
    logic             grant_found;
    logic [N_REQ-1:0] grant_oh;
    logic [CW-1:0]    wait_cnt;
    logic [31:0]      lat_a, lat_b, sel_a, sel_b;
    logic [1:0]       lat_op, sel_op;

    // Search starts one past the last winner and wraps, so every requester
    // is reached within N_REQ-1 operations.
    // NOTE: combinational blocks give every output a default first and use
    // blocking assignments, so cand chains correctly and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_grant;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + IW'(1);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[2*i +: 2];
            end
            req_ready[i] = (state == IDLE) && grant_found && !reset && (grant_idx == IW'(i));
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments;
    // the latched operands are reset too so every flop shares one async clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            grant_oh   <= '0;
            wait_cnt   <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            fpu_cs     <= 1'b0;
            fpu_addr   <= '0;
            fpu_wdata  <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        lat_a      <= sel_a;
                        lat_b      <= sel_b;
                        lat_op     <= sel_op;
                        last_grant <= grant_idx;
                        grant_oh   <= req_ready;
                        busy       <= 1'b1;
                        fpu_cs     <= 1'b1;
                        fpu_addr   <= ADDR_A;
                        fpu_wdata  <= sel_a;
                        state      <= WR_A;
                    end
                end
                WR_A: begin
                    fpu_addr  <= ADDR_B;
                    fpu_wdata <= lat_b;
                    state     <= WR_B;
                end
                WR_B: begin
                    fpu_addr  <= ADDR_CMD;
                    fpu_wdata <= {30'b0, lat_op};
                    state     <= WR_CMD;
                end
                WR_CMD: begin
                    fpu_cs    <= 1'b0;
                    fpu_addr  <= '0;
                    fpu_wdata <= '0;
                    wait_cnt  <= CW'(RESULT_WAIT - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_data  <= fpu_rdata;
                        rsp_valid <= grant_oh;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    fpu_cs   <= 1'b0;
                    fpu_addr <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: a small FPU peripheral, a schedule-based reference
// model checked every cycle, and directed plus randomized stimulus.
module tb_fpu_arbiter;
    localparam int N_REQ       = 4;
    localparam int RESULT_WAIT = 1;
    localparam int LAT         = 4 + RESULT_WAIT;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [32*N_REQ-1:0]  req_a = '0;
    logic [32*N_REQ-1:0]  req_b = '0;
    logic [2*N_REQ-1:0]   req_op = '0;
    logic [N_REQ-1:0]     rsp_valid;
    logic [31:0]          rsp_data;
    logic                 busy;
    logic                 fpu_cs;
    logic [12:0]          fpu_addr;
    logic [31:0]          fpu_wdata;
    logic [31:0]          fpu_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fpu_arbiter #(.N_REQ(N_REQ), .RESULT_WAIT(RESULT_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .fpu_cs(fpu_cs), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Single-precision <-> real for normal numbers and zero; operands are small integers.
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == '0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == '0) return 32'h0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'd1:    return r2sp(sp2r(a) + sp2r(b));
            2'd2:    return r2sp(sp2r(a) - sp2r(b));
            2'd3:    return r2sp(sp2r(a) * sp2r(b));
            default: return 32'h7FC00000;
        endcase
    endfunction

    // FPU peripheral: operand registers at 0x000/0x004, command at 0x008 registers the result.
    logic [31:0] fpu_ra, fpu_rb;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_ra    <= '0;
            fpu_rb    <= '0;
            fpu_rdata <= '0;
        end else if (fpu_cs) begin
            case (fpu_addr)
                13'h000: fpu_ra <= fpu_wdata;
                13'h004: fpu_rb <= fpu_wdata;
                13'h008: fpu_rdata <= fpu_calc(fpu_ra, fpu_rb, fpu_wdata[1:0]);
                default: ;
            endcase
        end
    end

    // Reference model: an operation is described by who was accepted and how
    // many cycles ago; all outputs follow from that age.
    int               m_last = N_REQ - 1;
    int               m_cur  = -1;
    int               m_age  = 0;
    int               win, idx;
    logic [31:0]      m_a, m_b, m_rsp = '0;
    logic [1:0]       m_op;
    logic [N_REQ-1:0] e_ready, e_valid;
    logic             e_busy, e_cs;
    logic [12:0]      e_addr;
    logic [31:0]      e_wdata;

    always @(negedge clk) begin
        e_ready = '0; e_valid = '0; e_busy = 1'b0; e_cs = 1'b0; e_addr = '0; e_wdata = '0;
        win = -1;
        if (reset) begin
            m_last = N_REQ - 1;
            m_cur  = -1;
            m_rsp  = '0;
        end else if (m_cur < 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (m_last + k) % N_REQ;
                if (win < 0 && req_valid[idx]) win = idx;
            end
            if (win >= 0) e_ready[win] = 1'b1;
        end else begin
            e_busy = 1'b1;
            case (m_age)
                1: begin e_cs = 1'b1; e_addr = 13'h000; e_wdata = m_a; end
                2: begin e_cs = 1'b1; e_addr = 13'h004; e_wdata = m_b; end
                3: begin e_cs = 1'b1; e_addr = 13'h008; e_wdata = {30'b0, m_op}; end
                default: ;
            endcase
            if (m_age == LAT) begin
                e_valid[m_cur] = 1'b1;
                m_rsp = fpu_calc(m_a, m_b, m_op);
            end
        end
        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_valid);
        check("rsp_data", rsp_data, m_rsp);
        check("busy", busy, e_busy);
        check("fpu_cs", fpu_cs, e_cs);
        check("fpu_addr", fpu_addr, e_addr);
        check("fpu_wdata", fpu_wdata, e_wdata);
        if (!reset) begin
            if (m_cur >= 0) begin
                if (m_age == LAT) m_cur = -1;
                else m_age++;
            end else if (win >= 0) begin
                m_cur  = win;
                m_age  = 1;
                m_last = win;
                m_a    = req_a[32*win +: 32];
                m_b    = req_b[32*win +: 32];
                m_op   = req_op[2*win +: 2];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic v);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_op[2*r +: 2]  = op;
        req_valid[r]      = v;
    endtask

    // Issue one operation from requester r and check accept, bus order, latency and result.
    task automatic run_op(input string name, input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] want, output int t_acc);
        int t_rsp;
        drive(r, a, b, op, 1'b1);
        t_acc = -1;
        for (int n = 0; n < 60 && t_acc < 0; n++) begin
            #1;
            if (req_ready[r]) t_acc = cyc;
            else tick();
        end
        check({name, "_accepted"}, t_acc >= 0, 1'b1);
        if (t_acc < 0) begin
            req_valid[r] = 1'b0;
            return;
        end
        tick();
        req_valid[r] = 1'b0;
        t_rsp = -1;
        for (int n = 1; n < 40 && t_rsp < 0; n++) begin
            #1;
            if (n <= 3) begin
                check({name, "_bus_cs"}, fpu_cs, 1'b1);
                check({name, "_bus_addr"}, fpu_addr, 13'(4 * (n - 1)));
            end
            if (rsp_valid[r]) t_rsp = cyc;
            else tick();
        end
        check({name, "_latency"}, t_rsp - t_acc, LAT);
        check({name, "_data"}, rsp_data, want);
        if (t_rsp >= 0) tick();
    endtask

    initial begin
        int t1, t2, ng, nr, g3, idle_cs;
        int gseq[5];
        int rwho[5];
        int rcyc[5];
        logic [31:0] rdat[5];
        logic [31:0] fair_want[4];
        fair_want[0] = 32'h40000000; fair_want[1] = 32'h40800000;
        fair_want[2] = 32'h40C00000; fair_want[3] = 32'h41000000;

        // Reset values
        @(posedge clk); #1;
        check("rst_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_fpu_cs", fpu_cs, 1'b0);
        tick();
        reset = 1'b0;

        run_op("add", 0, 32'h3F800000, 32'h40000000, 2'd1, 32'h40400000, t1);
        run_op("sub", 1, 32'h40A00000, 32'h40400000, 2'd2, 32'h40000000, t1);
        run_op("mul", 1, 32'h40000000, 32'h40400000, 2'd3, 32'h40C00000, t2);
        check("b2b_spacing", t2 - t1, LAT + 1);
        run_op("inv_op", 2, 32'h3F800000, 32'h40000000, 2'd0, 32'h7FC00000, t1);
        #1;
        check("inv_back_idle", busy, 1'b0);

        // Fairness: all four requesters held valid from reset
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++) drive(i, r2sp(real'(i + 1)), 32'h40000000, 2'd3, 1'b1);
        tick(); tick();
        reset = 1'b0;
        ng = 0; nr = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    if (ng < 5) gseq[ng] = i;
                    ng++;
                end
                if (rsp_valid[i]) begin
                    if (nr < 5) begin rwho[nr] = i; rdat[nr] = rsp_data; rcyc[nr] = cyc; end
                    nr++;
                end
            end
            tick();
        end
        check("fair_grant_count", ng >= 5, 1'b1);
        check("fair_rsp_count", nr >= 5, 1'b1);
        if (ng >= 5 && nr >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("fair_grant_order", gseq[k], k % N_REQ);
                check("fair_rsp_who", rwho[k], k % N_REQ);
                check("fair_rsp_data", rdat[k], fair_want[k % N_REQ]);
                if (k > 0) check("fair_rsp_spacing", rcyc[k] - rcyc[k-1], LAT + 1);
            end
        end
        req_valid = '0;
        repeat (LAT + 3) tick();

        // Reset asserted during WR_CMD
        drive(1, 32'h40400000, 32'h40400000, 2'd1, 1'b1);
        t1 = -1;
        for (int n = 0; n < 20 && t1 < 0; n++) begin
            #1;
            if (req_ready[1]) t1 = cyc;
            else tick();
        end
        check("mid_accepted", t1 >= 0, 1'b1);
        tick();
        req_valid[1] = 1'b0;
        tick(); tick();
        check("mid_wr_cmd_addr", fpu_addr, 13'h008);
        reset = 1'b1;
        #1;
        check("mid_rst_cs", fpu_cs, 1'b0);
        check("mid_rst_addr", fpu_addr, '0);
        check("mid_rst_wdata", fpu_wdata, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rsp_data", rsp_data, '0);
        check("mid_rst_rsp_valid", rsp_valid, '0);
        tick(); tick();
        reset = 1'b0;
        drive(0, 32'h3F800000, 32'h3F800000, 2'd1, 1'b1);
        drive(2, 32'h3F800000, 32'h3F800000, 2'd1, 1'b1);
        #1;
        check("post_rst_priority", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        run_op("post_rst_add", 2, 32'h3F800000, 32'h3F800000, 2'd1, 32'h40000000, t1);

        // Request withdrawn while busy is never granted
        drive(0, 32'h40000000, 32'h40000000, 2'd3, 1'b1);
        t1 = -1;
        for (int n = 0; n < 20 && t1 < 0; n++) begin
            #1;
            if (req_ready[0]) t1 = cyc;
            else tick();
        end
        check("wd_accepted", t1 >= 0, 1'b1);
        tick();
        req_valid[0] = 1'b0;
        drive(3, 32'h40000000, 32'h3F800000, 2'd1, 1'b1);
        tick();
        req_valid[3] = 1'b0;
        g3 = 0; idle_cs = 0;
        for (int n = 0; n < 15; n++) begin
            #1;
            if (req_ready[3]) g3++;
            if (!busy && fpu_cs) idle_cs++;
            tick();
        end
        check("wd_never_granted", g3, 0);
        check("wd_idle_cs", idle_cs, 0);

        // Randomized traffic, including occasional single-cycle resets
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(249) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(3) == 0) req_valid[i] = 1'($urandom_range(1));
                if ($urandom_range(1) == 0) begin
                    req_a[32*i +: 32] = r2sp(real'($urandom_range(15)));
                    req_b[32*i +: 32] = r2sp(real'($urandom_range(15)));
                    req_op[2*i +: 2]  = 2'($urandom_range(3));
                end
            end
            tick();
        end
        reset = 1'b0;
        req_valid = '0;
        repeat (LAT + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares one memory-mapped `fpu_top` instance among `N_REQ` requesters. Each requester hands over two IEEE-754 single-precision operands and an opcode through a valid/ready handshake. The arbiter drives the FPU bus: operand A, operand B, then command. It captures the registered result and returns it to the requester with a one-cycle response pulse. It sits between the processor-side clients and the FPU register interface.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 1..8.
- `RESULT_WAIT`, default 1: cycles spent in WAIT after the command write before the result is captured; legal range ≥1.
- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester operation request.
- `req_ready`  out  N_REQ: one-hot acceptance; at most one bit high.
- `req_a`  in  32*N_REQ: operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*N_REQ: operand B; same packing as `req_a`.
- `req_op`  in  2*N_REQ: opcode; 1=ADD, 2=SUB, 3=MUL, 0=invalid.
- `rsp_valid`  out  N_REQ: one-hot, one-cycle result strobe to the granted requester.
- `rsp_data`  out  32: result word; held until the next capture.
- `busy`  out  1: high in every state except IDLE.
- `fpu_cs`  out  1: FPU chip_select.
- `fpu_addr`  out  13: FPU register address.
- `fpu_wdata`  out  32: FPU data_in.
- `fpu_rdata`  in  32: FPU data_out.

## Operation
- FSM states: IDLE → WR_A → WR_B → WR_CMD → WAIT → RESP → IDLE.
- **IDLE**
  - The winner w is the first asserted `req_valid` bit, searching from (`last_grant`+1) mod N_REQ and wrapping.
  - `req_ready[w]`=1 combinationally in the same cycle.
  - On that edge: latch A, B and op for w; set `last_grant`=w; go to WR_A.
  - With no valid requests: stay in IDLE, all `req_ready`=0.
- **WR_A:** `fpu_cs`=1, `fpu_addr`=13'h000, `fpu_wdata`=latched A.
- **WR_B:** `fpu_cs`=1, `fpu_addr`=13'h004, `fpu_wdata`=latched B.
- **WR_CMD:** `fpu_cs`=1, `fpu_addr`=13'h008, `fpu_wdata`={30'b0, op}.
- **WAIT**
  - Counter runs from RESULT_WAIT-1 down to 0. `fpu_cs`=0.
  - On the last WAIT cycle: `rsp_data`<=`fpu_rdata`; go to RESP.
- **RESP:** `rsp_valid[w]`=1 for exactly one cycle, then IDLE.
- **FPU bus outside WR states:** `fpu_cs`=0, `fpu_addr`=0, `fpu_wdata`=0. FPU bus outputs are decoded from the registered state and latched operands only; they never depend combinationally on the request inputs.
- **Opcode 0** is forwarded unchanged as command 0. The FPU returns 32'h7FC00000, which is delivered as a normal response.
- **Request inputs after acceptance:** ignored until the next IDLE. A requester may change or drop `req_valid` freely.
- **Request dropped in IDLE:** a `req_valid` that falls before `req_ready` is granted has no effect.
- **N_REQ=1:** the arbiter degenerates to a fixed grant of requester 0.

## Timing
- **Reset values:** state=IDLE, `last_grant`=N_REQ-1 (requester 0 wins first), WAIT counter=0. Outputs `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `fpu_cs`=0, `fpu_addr`=0, `fpu_wdata`=0.
- **Cycle schedule:** with acceptance in cycle T:
  - WR_A at T+1, WR_B at T+2, WR_CMD at T+3.
  - The FPU result is registered at the end of T+3, so `fpu_rdata` is valid from T+4.
  - Capture happens at the end of T+3+RESULT_WAIT; `rsp_valid` is high in T+4+RESULT_WAIT.
- **Latency:** accept-to-response = 4+RESULT_WAIT cycles.
- **Throughput:** the next acceptance is possible in cycle T+5+RESULT_WAIT, giving 5+RESULT_WAIT cycles per operation (6 by default).
- **Simultaneous requests:** resolved purely by round-robin order. No requester waits more than N_REQ-1 operations.
- **Reset asserted mid-operation:** immediate return to reset values. The in-flight operation is discarded with no `rsp_valid`. The FPU shares `reset`, so its registers also clear.

## Test plan
- **ADD:** req0 with A=32'h3F800000, B=32'h40000000, op=1 → `req_ready[0]` in the accept cycle; `rsp_valid[0]` 5 cycles later with `rsp_data`=32'h40400000; bus sequence addr 0x000, 0x004, 0x008 on consecutive cycles.
- **SUB and MUL back-to-back from req1:**
  - A=32'h40A00000, B=32'h40400000, op=2 → 32'h40000000.
  - Then A=32'h40000000, B=32'h40400000, op=3 → 32'h40C00000; the second accept occurs exactly 6 cycles after the first.
- **Fairness:** all four `req_valid` held high from reset → grants in order 0,1,2,3,0; `rsp_valid` one-hot and 6 cycles apart; each response carries its own requester's result.
- **Invalid opcode:** op=0 → `rsp_data`=32'h7FC00000; the FSM returns to IDLE normally.
- **Reset mid-operation:** assert `reset` during WR_CMD → all outputs 0 in the same cycle and no `rsp_valid`. After release, a req2 ADD of 32'h3F800000+32'h3F800000 returns 32'h40000000, and req0 retains first priority.
- **Withdrawn request:** `req_valid[3]` pulsed while `busy` and dropped before IDLE → never granted; `fpu_cs` remains 0 throughout IDLE.
